morse_decoder: RTL and testbench

Receive-side counterpart to the ASCII-to-Morse encoder path. Samples a single on/off key line and times marks and gaps in Morse units. Assembles elements into a code/length pair using the encoder's bit convention, then decodes that pair back to 7-bit ASCII. Sits between the key/receiver input pin and any character sink (UART TX, display buffer) and emits one-cycle ASCII strobes.

---
 rtl/morse_pkg.sv | 26 ++
 rtl/morse_decoder_if.sv | 24 ++
 rtl/morse_2_ascii_lut.sv | 79 +++++++
 rtl/morse_decoder.sv | 183 ++++++++++++++++++
 tb/tb_morse_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// +----------------------------------------------------------------------------+
// | morse_pkg                                                                  |
// | Shared constants and state type for the Morse receive path.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package morse_pkg;

  localparam logic       DOT            = 1'b0;
  localparam logic       DASH           = 1'b1;
  localparam logic [2:0] MAX_LEN        = 3'd7;
  localparam logic [2:0] DASH_UNITS     = 3'd2;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd2;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd6;
  localparam logic [6:0] SPACE          = 7'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/morse_decoder_if.sv
// +----------------------------------------------------------------------------+
// | morse_decoder_if                                                           |
// | Character strobe and debug element bus from the Morse decoder to its sink. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface morse_decoder_if;
  logic [6:0] ascii_code;
  logic       ascii_valid;
  logic       code_err;
  logic [6:0] morse_code;
  logic [2:0] morse_len;

  modport master (
    output ascii_code, ascii_valid, code_err, morse_code, morse_len
  );

  modport slave (
    input ascii_code, ascii_valid, code_err, morse_code, morse_len
  );
endinterface

`default_nettype wire

// File: rtl/morse_2_ascii_lut.sv
// +----------------------------------------------------------------------------+
// | morse_2_ascii_lut                                                          |
// | Registered {len, code} -> ASCII table; element 0 sits in code bit 0.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module morse_2_ascii_lut
  import morse_pkg::*;
(
  input  wire        clk_24,
  input  wire        rst,
  input  wire        i_start,
  input  wire  [6:0] i_code,
  input  wire  [2:0] i_len,
  input  wire        i_ovf,
  output logic [6:0] o_ascii_code,
  output logic       o_ascii_valid,
  output logic       o_code_err
);

  // Returns 0 for any pattern outside the table; no valid character is NUL.
  function automatic logic [6:0] lookup(input logic [2:0] len, input logic [6:0] code);
    logic [6:0] a;
    a = 7'd0;
    case ({len, code})
      10'b001_0000000: a = 7'd69;  10'b001_0000001: a = 7'd84;
      10'b010_0000000: a = 7'd73;  10'b010_0000010: a = 7'd65;
      10'b010_0000001: a = 7'd78;  10'b010_0000011: a = 7'd77;
      10'b011_0000000: a = 7'd83;  10'b011_0000100: a = 7'd85;
      10'b011_0000010: a = 7'd82;  10'b011_0000110: a = 7'd87;
      10'b011_0000001: a = 7'd68;  10'b011_0000101: a = 7'd75;
      10'b011_0000011: a = 7'd71;  10'b011_0000111: a = 7'd79;
      10'b100_0000000: a = 7'd72;  10'b100_0001000: a = 7'd86;
      10'b100_0000100: a = 7'd70;  10'b100_0000010: a = 7'd76;
      10'b100_0000110: a = 7'd80;  10'b100_0001110: a = 7'd74;
      10'b100_0000001: a = 7'd66;  10'b100_0001001: a = 7'd88;
      10'b100_0000101: a = 7'd67;  10'b100_0001101: a = 7'd89;
      10'b100_0000011: a = 7'd90;  10'b100_0001011: a = 7'd81;
      10'b101_0011110: a = 7'd49;  10'b101_0011100: a = 7'd50;
      10'b101_0011000: a = 7'd51;  10'b101_0010000: a = 7'd52;
      10'b101_0000000: a = 7'd53;  10'b101_0000001: a = 7'd54;
      10'b101_0000011: a = 7'd55;  10'b101_0000111: a = 7'd56;
      10'b101_0001111: a = 7'd57;  10'b101_0011111: a = 7'd48;
      10'b101_0000010: a = 7'd38;  10'b101_0001101: a = 7'd40;
      10'b101_0001010: a = 7'd43;  10'b101_0001001: a = 7'd47;
      10'b101_0010001: a = 7'd61;
      10'b110_0110101: a = 7'd33;  10'b110_0010010: a = 7'd34;
      10'b110_0011110: a = 7'd39;  10'b110_0101101: a = 7'd41;
      10'b110_0110011: a = 7'd44;  10'b110_0100001: a = 7'd45;
      10'b110_0101010: a = 7'd46;  10'b110_0000111: a = 7'd58;
      10'b110_0010101: a = 7'd59;  10'b110_0001100: a = 7'd63;
      10'b110_0010110: a = 7'd64;  10'b110_0101100: a = 7'd95;
      10'b111_1001000: a = 7'd36;  10'b111_0000000: a = SPACE;
      default:         a = 7'd0;
    endcase
    return a;
  endfunction

  logic [6:0] w_ascii;
  assign w_ascii = i_ovf ? 7'd0 : lookup(i_len, i_code);

  always_ff @(posedge clk_24) begin
    if (rst) begin
      o_ascii_code  <= 7'd0;
      o_ascii_valid <= 1'b0;
      o_code_err    <= 1'b0;
    end else begin
      o_ascii_valid <= i_start;
      o_code_err    <= i_start && (w_ascii == 7'd0);
      if (i_start) begin
        o_ascii_code <= w_ascii;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/morse_decoder.sv
// +----------------------------------------------------------------------------+
// | morse_decoder                                                              |
// | Times key marks/gaps in Morse units and emits decoded ASCII strobes.       |
// | Option: MORSE_DEC_DEBOUNCE_EN enables the key debounce filter.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module morse_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 1_440_000,
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  wire             clk_24,
  input  wire             rst,
  input  wire             key_in,
  morse_decoder_if.master bus
);

  localparam int               c_CNT_W       = $clog2(UNIT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(UNIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_START = (UNIT_CYCLES > 1) ? c_CNT_W'(1) : '0;
  localparam logic [2:0]       c_UNITS_START = (UNIT_CYCLES > 1) ? 3'd0 : 3'd1;
  localparam logic [2:0]       c_UNITS_MAX   = 3'd7;

  logic r_sync1, r_sync2, r_key_d, w_key_s, w_edge;

  always_ff @(posedge clk_24) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MORSE_DEC_DEBOUNCE_EN
  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [c_DB_W-1:0] r_db_cnt;
  logic              r_db_key;

  always_ff @(posedge clk_24) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_db_key <= 1'b0;
    end else if (r_sync2 == r_db_key) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_key <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_key_s = r_db_key;
`else
  logic w_unused_db;
  assign w_unused_db = ^DEBOUNCE_CYCLES;
  assign w_key_s     = r_sync2;
`endif

  assign w_edge = w_key_s ^ r_key_d;

  logic [c_CNT_W-1:0] r_unit_cnt;
  logic [2:0]         r_elem_units;
  logic               r_units_inc;
  logic               w_char_end, w_word_end;

  // The edge cycle itself is the first elapsed cycle of the new level, so a
  // level held d cycles reads floor(d/UNIT_CYCLES) units when it ends.
  always_ff @(posedge clk_24) begin
    if (rst) begin
      r_key_d      <= 1'b0;
      r_unit_cnt   <= '0;
      r_elem_units <= 3'd0;
      r_units_inc  <= 1'b0;
    end else begin
      r_key_d     <= w_key_s;
      r_units_inc <= 1'b0;
      if (w_edge || w_word_end) begin
        r_unit_cnt   <= c_CNT_START;
        r_elem_units <= c_UNITS_START;
      end else if (r_unit_cnt == c_CNT_LAST) begin
        r_unit_cnt <= '0;
        if (r_elem_units != c_UNITS_MAX) begin
          r_elem_units <= r_elem_units + 3'd1;
          r_units_inc  <= 1'b1;
        end
      end else begin
        r_unit_cnt <= r_unit_cnt + 1'b1;
      end
    end
  end

  state_t     r_state;
  logic [6:0] r_morse_code;
  logic [2:0] r_morse_len;
  logic       r_ovf, r_word_pend;

  assign w_char_end = (r_state == GAP) && r_units_inc &&
                      (r_elem_units == CHAR_GAP_UNITS) && (r_morse_len != 3'd0);
  assign w_word_end = (r_state == GAP) && r_units_inc &&
                      (r_elem_units == WORD_GAP_UNITS) && r_word_pend;

  always_ff @(posedge clk_24) begin
    if (rst) begin
      r_state      <= IDLE;
      r_morse_code <= 7'd0;
      r_morse_len  <= 3'd0;
      r_ovf        <= 1'b0;
      r_word_pend  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_key_s) r_state <= MARK;
        end
        MARK: begin
          if (!w_key_s) begin
            r_state <= GAP;
            if (r_morse_len == MAX_LEN) begin
              r_ovf <= 1'b1;
            end else begin
              r_morse_code[r_morse_len] <= (r_elem_units >= DASH_UNITS) ? DASH : DOT;
              r_morse_len               <= r_morse_len + 3'd1;
            end
          end
        end
        GAP: begin
          if (w_char_end) begin
            r_morse_code <= 7'd0;
            r_morse_len  <= 3'd0;
            r_ovf        <= 1'b0;
            r_word_pend  <= 1'b1;
          end
          if (w_word_end) begin
            r_word_pend <= 1'b0;
            r_state     <= w_key_s ? MARK : IDLE;
          end else if (w_key_s) begin
            r_state <= MARK;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A word end reuses the table entry for seven dots, which maps to space.
  logic       w_lut_start, w_lut_ovf;
  logic [6:0] w_lut_code;
  logic [2:0] w_lut_len;

  assign w_lut_start = w_char_end | w_word_end;
  assign w_lut_code  = w_word_end ? 7'd0 : r_morse_code;
  assign w_lut_len   = w_word_end ? MAX_LEN : r_morse_len;
  assign w_lut_ovf   = w_word_end ? 1'b0 : r_ovf;

  logic [6:0] w_ascii_code;
  logic       w_ascii_valid, w_code_err;

  morse_2_ascii_lut u_lut (
    .clk_24        (clk_24),
    .rst           (rst),
    .i_start       (w_lut_start),
    .i_code        (w_lut_code),
    .i_len         (w_lut_len),
    .i_ovf         (w_lut_ovf),
    .o_ascii_code  (w_ascii_code),
    .o_ascii_valid (w_ascii_valid),
    .o_code_err    (w_code_err)
  );

  assign bus.ascii_code  = w_ascii_code;
  assign bus.ascii_valid = w_ascii_valid;
  assign bus.code_err    = w_code_err;
  assign bus.morse_code  = r_morse_code;
  assign bus.morse_len   = r_morse_len;

endmodule

`default_nettype wire

// File: tb/tb_morse_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_morse_decoder                                                           |
// | Directed and random key timing against a table-driven Morse reference.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_morse_decoder;

  localparam int U  = 10;
  localparam int DB = 3;

  logic clk_24 = 1'b0;
  logic rst    = 1'b1;
  logic key_in = 1'b0;

  always #5 clk_24 = ~clk_24;

  morse_decoder_if dif ();

  morse_decoder #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_24 (clk_24),
    .rst    (rst),
    .key_in (key_in),
    .bus    (dif)
  );

  typedef struct { int code; int err; int t; } ev_t;

  ev_t   got_q[$];
  ev_t   exp_q[$];
  int    segs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    b2b      = 0;
  logic  prev_v   = 1'b0;

  string chars = {"ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789!", 8'h22, "$&'()+,-./:;=?@_ "};
  string pats [55] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----.",
    "-.-.--", ".-..-.", "...-..-", ".-...", ".----.", "-.--.", "-.--.-",
    ".-.-.", "--..--", "-....-", ".-.-.-", "-..-.", "---...", "-.-.-.",
    "-...-", "..--..", ".--.-.", "..--.-", "......."
  };

  always @(posedge clk_24) cyc <= cyc + 1;

  always @(negedge clk_24) begin
    if (dif.ascii_valid) begin
      got_q.push_back('{code: int'(dif.ascii_code), err: int'(dif.code_err), t: cyc});
      if (prev_v) b2b++;
    end
    prev_v = dif.ascii_valid;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(posedge clk_24);
    #1;
  endtask

  task automatic run_segs();
    for (int i = 0; i < segs.size(); i++) hold(i % 2 == 0, segs[i]);
    segs.delete();
  endtask

  task automatic exp_ev(input int code, input int err);
    exp_q.push_back('{code: code, err: err, t: 0});
  endtask

  function automatic int decode(input string el);
    if (el.len() > 7) return 0;
    for (int k = 0; k < 55; k++) if (pats[k] == el) return int'(chars[k]);
    return 0;
  endfunction

  // Reference: marks of >= 2 units are dashes; gaps of >= 2 units end a
  // character, gaps of >= 6 units after a character add a space.
  function automatic void model_segs();
    string el = "";
    bit    pend = 1'b0;
    int    c;
    for (int i = 0; i < segs.size(); i++) begin
      if (i % 2 == 0) begin
        if (segs[i] >= 2 * U) el = {el, "-"};
        else                  el = {el, "."};
      end else begin
        if (segs[i] >= 2 * U && el.len() > 0) begin
          c = decode(el);
          exp_q.push_back('{code: c, err: (c == 0) ? 1 : 0, t: 0});
          el   = "";
          pend = 1'b1;
        end
        if (segs[i] >= 6 * U && pend) begin
          exp_q.push_back('{code: 32, err: 0, t: 0});
          pend = 1'b0;
        end
      end
    end
  endfunction

  task automatic compare(input string tag);
    repeat (5) @(posedge clk_24);
    #1;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_code%0d", tag, i), got_q[i].code, exp_q[i].code);
      check_eq($sformatf("%s_err%0d", tag, i), got_q[i].err, exp_q[i].err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic add_pat(input string p, input int last_gap);
    for (int j = 0; j < p.len(); j++) begin
      if (p[j] == "-") segs.push_back($urandom_range(2 * U, 4 * U + 5));
      else             segs.push_back($urandom_range(DB, 2 * U - 1));
      if (j == p.len() - 1) segs.push_back(last_gap);
      else                  segs.push_back($urandom_range(DB, 2 * U - 1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string p;
    int    nch, gap;

    repeat (3) @(posedge clk_24);
    #1;
    check_eq("rst_ascii_code", dif.ascii_code, 0);
    check_eq("rst_ascii_valid", dif.ascii_valid, 0);
    check_eq("rst_code_err", dif.code_err, 0);
    check_eq("rst_morse_code", dif.morse_code, 0);
    check_eq("rst_morse_len", dif.morse_len, 0);
    rst = 1'b0;
    hold(1'b0, 5);

    segs = '{10, 80};
    run_segs();
    exp_ev(69, 0); exp_ev(32, 0);
    repeat (5) @(posedge clk_24);
    if (got_q.size() >= 2) check_eq("E_space_delay", got_q[1].t - got_q[0].t, 4 * U);
    compare("E");

    hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 30); hold(1'b0, 10);
    check_eq("A_dbg_code", dif.morse_code, 2);
    check_eq("A_dbg_len", dif.morse_len, 2);
    hold(1'b0, 70);
    exp_ev(65, 0); exp_ev(32, 0);
    compare("A");

    segs = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 80};
    run_segs();
    exp_ev(53, 0); exp_ev(32, 0);
    compare("five");

    segs = '{30, 10, 30, 10, 30, 10, 30, 10, 30, 80};
    run_segs();
    exp_ev(48, 0); exp_ev(32, 0);
    compare("zero");

    for (int i = 0; i < 8; i++) begin
      segs.push_back(10);
      segs.push_back((i == 7) ? 30 : 10);
    end
    segs.push_back(30); segs.push_back(80);
    run_segs();
    exp_ev(0, 1); exp_ev(84, 0); exp_ev(32, 0);
    compare("ovf");

    segs = '{10, 10, 10, 5};
    run_segs();
    rst = 1'b1;
    @(posedge clk_24);
    #1;
    rst = 1'b0;
    check_eq("midrst_len", dif.morse_len, 0);
    segs = '{30, 80};
    run_segs();
    exp_ev(84, 0); exp_ev(32, 0);
    compare("midrst");

    segs = '{2, 80};
    run_segs();
`ifndef MORSE_DEC_DEBOUNCE_EN
    exp_ev(69, 0); exp_ev(32, 0);
`endif
    compare("glitch");

    for (int w = 0; w < 30; w++) begin
      nch = $urandom_range(1, 3);
      for (int c = 0; c < nch; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          p = "";
          for (int e = 0; e < $urandom_range(1, 8); e++) begin
            if ($urandom_range(0, 1) == 1) p = {p, "-"};
            else                           p = {p, "."};
          end
        end else begin
          p = pats[$urandom_range(0, 54)];
        end
        gap = (c == nch - 1) ? $urandom_range(6 * U, 9 * U) : $urandom_range(2 * U, 6 * U - 1);
        add_pat(p, gap);
      end
    end
    segs.push_back(10);
    segs.push_back(80);
    model_segs();
    run_segs();
    compare("rand");

    check_eq("no_back_to_back", b2b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
